rv_writeback: RTL
=================

# rv_writeback

Writeback stage of the uRV pipeline, directly downstream of the execute stage. It takes the registered execute results (ALU value, destination register, load/store flags, data-memory address), waits for data-memory completion of loads and stores, and aligns and sign-extends load data. It then issues a single registered write to the register file and holds the pipeline via a stall request while a memory access is outstanding.

## Interface
Parameters:
- none.

Ports:
- clk_i  in  1  sole clock; one clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous, active-high reset.
- x_fun_i  in  3  funct3 of the instruction (`LDST_B`/`LDST_H`/`LDST_L`, plus BU=3'b100 and HU=3'b101).
- x_load_i  in  1  single-cycle pulse: a load was issued to data memory last cycle.
- x_store_i  in  1  single-cycle pulse: a store was issued last cycle.
- x_rd_i  in  5  destination register index.
- x_rd_value_i  in  32  ALU/jump result for non-load writes.
- x_rd_write_i  in  1  non-memory instruction writes rd.
- x_dm_addr_i  in  32  load/store byte address; only [1:0] is used.
- dm_data_l_i  in  32  load data; valid when dm_load_done_i=1.
- dm_load_done_i  in  1  load data valid this cycle.
- dm_store_done_i  in  1  store accepted this cycle.
- w_stall_req_o  out  1  combinational; stalls execute and earlier stages.
- rf_rd_o  out  5  register-file write index.
- rf_rd_value_o  out  32  register-file write data.
- rf_rd_write_o  out  1  register-file write enable.
- w_retire_o  out  1  one-cycle pulse per completed instruction.

## Operation
- FSM states: IDLE, WAIT_LOAD, WAIT_STORE.
- IDLE, x_load_i=1:
  - If dm_load_done_i=1 in the same cycle, complete at once.
  - Otherwise capture fun, rd and addr[1:0], then go to WAIT_LOAD.
- IDLE, x_store_i=1:
  - If dm_store_done_i=1, complete at once.
  - Otherwise go to WAIT_STORE.
- IDLE, x_rd_write_i=1: complete as a non-memory write.
- IDLE, no valid input: no completion.
- WAIT_LOAD: complete on dm_load_done_i using the captured fun/rd/addr, then return to IDLE.
- WAIT_STORE: complete on dm_store_done_i, then return to IDLE.
- Load alignment:
  - B/BU select byte addr[1:0]; B sign-extends, BU zero-extends.
  - H/HU select halfword addr[1] (addr[0] ignored); H sign-extends, HU zero-extends.
  - L passes the word through (addr[1:0] ignored).
  - No misalignment trap.
  - Other fun codes write 32'h0.
- Completion actions:
  - Register rf_rd_write_o=1 when the instruction is a load or a non-memory write and rd≠0. Stores and rd=0 never write.
  - Pulse w_retire_o for every completion, including stores and rd=0 writes.
- Error and ignore cases:
  - dm_*_done_i while no access of that kind is pending: ignored.
  - x_load_i or x_store_i while in a WAIT state: protocol error, ignored. Inputs are not re-captured.
  - x_load_i and x_store_i both high: the load wins.

## Timing
- Reset values: state=IDLE, rf_rd_o=0, rf_rd_value_o=0, rf_rd_write_o=0, w_retire_o=0, w_stall_req_o=0.
- Reset mid-WAIT aborts the pending access. No write is issued.
- Completion cycle C drives rf_* and w_retire_o registered at C+1, for exactly one cycle.
  - Example: a non-memory write at cycle N appears at N+1.
  - Example: a load whose done arrives k cycles after x_load_i appears k+1 cycles after x_load_i.
- rf_rd_o and rf_rd_value_o hold their last values when rf_rd_write_o=0.
- w_stall_req_o = (IDLE & x_load_i & !dm_load_done_i) | (IDLE & x_store_i & !dm_store_done_i) | (WAIT_LOAD & !dm_load_done_i) | (WAIT_STORE & !dm_store_done_i).
  - It is combinational, with no register on the path.
  - It is deasserted in the done cycle.
- Throughput: one completion per cycle when done arrives with the x_* pulse. Back-to-back loads are sustained.

## Structure
- Funct3 constants come from the shared `rv_defs.v`: `LDST_B`, `LDST_H`, `LDST_L`, plus new `LDST_BU` and `LDST_HU`.
- Add FSM state encodings `WB_IDLE`, `WB_WAIT_LOAD` and `WB_WAIT_STORE` to `rv_defs.v`.
- One combinational sub-module, rv_load_align:
  - Inputs: data[31:0], fun[2:0], addr[1:0].
  - Output: value[31:0].
  - It is reused by the bench's reference model.

## Test plan
- ALU write: x_rd_write_i=1, rd=5, value=32'h1234_5678 at cycle N → rf_rd_write_o=1, rf_rd_o=5, rf_rd_value_o=32'h1234_5678 at N+1; w_stall_req_o=0 throughout.
- Load 2-cycle wait: x_load_i=1, fun=B, addr=...01, rd=7, done 2 cycles later with dm_data_l_i=32'h0000_8000 → w_stall_req_o high for 2 cycles; rf write of rd=7 with 32'hFFFF_FF80 one cycle after done. Repeat with BU → 32'h0000_0080.
- Halfword/word: H at addr[1]=1 with data 32'h8001_0000 → 32'hFFFF_8001; HU → 32'h0000_8001; L → data unchanged.
- Store and rd=0: a store with 3-cycle-late dm_store_done_i stalls 3 cycles, then gives a retire pulse with no rf write; a load to rd=0 gives a retire pulse with rf_rd_write_o=0.
- Reset mid-WAIT_LOAD: rst_i during a wait, then a late dm_load_done_i → no rf write, w_stall_req_o=0, all outputs at reset values.
- Back-to-back loads, each with same-cycle done → three consecutive rf writes, w_stall_req_o never asserted.

Source files
------------

// File: rtl/rv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage: load/store funct3 codes and FSM states.
// No logic; constants and types only.
// Imported by rv_writeback and rv_load_align.
package rv_writeback_pkg;

  // funct3 codes for loads/stores
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  // writeback FSM states
  typedef enum logic [1:0] {
    WB_IDLE       = 2'd0,
    WB_WAIT_LOAD  = 2'd1,
    WB_WAIT_STORE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/rv_load_align.sv
// Purpose: select and sign/zero-extend the loaded byte/halfword/word from a 32-bit memory word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output follows inputs.
module rv_load_align
  import rv_writeback_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  fun_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lane; misaligned halfwords simply ignore addr[0]
  always_comb begin
    byte_sel = data_i[7:0];
    case (addr_i)
      2'd0: byte_sel = data_i[7:0];
      2'd1: byte_sel = data_i[15:8];
      2'd2: byte_sel = data_i[23:16];
      2'd3: byte_sel = data_i[31:24];
      default: byte_sel = data_i[7:0];
    endcase
    half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];
  end

  // Extend the selected lane according to funct3; unknown codes produce zero
  always_comb begin
    value_o = 32'h0;
    case (fun_i)
      LDST_B:  value_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: value_o = {24'h0, byte_sel};
      LDST_H:  value_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: value_o = {16'h0, half_sel};
      LDST_L:  value_o = data_i;
      default: value_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv_writeback.sv
// Purpose: uRV writeback stage; waits for data-memory completion, aligns loads, writes the register file.
// Latency: results registered one cycle after the completion cycle (done cycle for memory ops).
// Backpressure: w_stall_req_o (combinational) holds upstream while a load/store is outstanding.
module rv_writeback
  import rv_writeback_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_stall_req_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        w_retire_o
);

  wb_state_e   state_q;
  logic [2:0]  fun_q;
  logic [4:0]  rd_q;
  logic [1:0]  addr_q;
  logic [4:0]  rf_rd_q;
  logic [31:0] rf_rd_value_q;
  logic        rf_rd_write_q;
  logic        retire_q;

  logic        in_wait_load;
  logic [2:0]  al_fun;
  logic [1:0]  al_addr;
  logic [31:0] load_value;
  logic        unused_addr_hi;

  // Only the byte offset of the address matters here
  assign unused_addr_hi = ^x_dm_addr_i[31:2];

  // While waiting, align with the captured fun/addr; otherwise use the live execute inputs
  assign in_wait_load = (state_q == WB_WAIT_LOAD);
  assign al_fun       = in_wait_load ? fun_q  : x_fun_i;
  assign al_addr      = in_wait_load ? addr_q : x_dm_addr_i[1:0];

  rv_load_align u_align (
    .data_i  (dm_data_l_i),
    .fun_i   (al_fun),
    .addr_i  (al_addr),
    .value_o (load_value)
  );

  // Stall whenever an access is pending and its done has not arrived this cycle
  assign w_stall_req_o =
      ((state_q == WB_IDLE)       &  x_load_i  & ~dm_load_done_i)                 |
      ((state_q == WB_IDLE)       & ~x_load_i  &  x_store_i & ~dm_store_done_i)   |
      ((state_q == WB_WAIT_LOAD)  & ~dm_load_done_i)                              |
      ((state_q == WB_WAIT_STORE) & ~dm_store_done_i);

  // Writeback FSM with registered register-file write and retire pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= WB_IDLE;
      fun_q         <= 3'h0;
      rd_q          <= 5'h0;
      addr_q        <= 2'h0;
      rf_rd_q       <= 5'h0;
      rf_rd_value_q <= 32'h0;
      rf_rd_write_q <= 1'b0;
      retire_q      <= 1'b0;
    end else begin
      rf_rd_write_q <= 1'b0;
      retire_q      <= 1'b0;
      case (state_q)
        WB_IDLE: begin
          if (x_load_i) begin
            if (dm_load_done_i) begin
              retire_q <= 1'b1;
              if (x_rd_i != 5'd0) begin
                rf_rd_write_q <= 1'b1;
                rf_rd_q       <= x_rd_i;
                rf_rd_value_q <= load_value;
              end
            end else begin
              fun_q   <= x_fun_i;
              rd_q    <= x_rd_i;
              addr_q  <= x_dm_addr_i[1:0];
              state_q <= WB_WAIT_LOAD;
            end
          end else if (x_store_i) begin
            if (dm_store_done_i) begin
              retire_q <= 1'b1;
            end else begin
              state_q <= WB_WAIT_STORE;
            end
          end else if (x_rd_write_i) begin
            retire_q <= 1'b1;
            if (x_rd_i != 5'd0) begin
              rf_rd_write_q <= 1'b1;
              rf_rd_q       <= x_rd_i;
              rf_rd_value_q <= x_rd_value_i;
            end
          end
        end
        WB_WAIT_LOAD: begin
          if (dm_load_done_i) begin
            retire_q <= 1'b1;
            if (rd_q != 5'd0) begin
              rf_rd_write_q <= 1'b1;
              rf_rd_q       <= rd_q;
              rf_rd_value_q <= load_value;
            end
            state_q <= WB_IDLE;
          end
        end
        WB_WAIT_STORE: begin
          if (dm_store_done_i) begin
            retire_q <= 1'b1;
            state_q  <= WB_IDLE;
          end
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign rf_rd_o       = rf_rd_q;
  assign rf_rd_value_o = rf_rd_value_q;
  assign rf_rd_write_o = rf_rd_write_q;
  assign w_retire_o    = retire_q;

endmodule
